gen_slot_sequencer: RTL and testbench

- Controller for the generator's three-phase slot counter; cycles an active slot 1 -> 2 -> 3 -> 1.
- Owns the prescaler that produces the slot-advance tick.
- Adds run/stop and single-step control plus a per-slot skip mask, so downstream channel logic sees one enabled slot at a time.

---
 rtl/gen_slot_sequencer.sv | 179 +++++++++++++++++
 tb/tb_gen_slot_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gen_slot_sequencer.sv
// -----------------------------------------------------------------------------
// gen_slot_sequencer
//
// Purpose:
//   Drives the generator's three-phase slot counter. A prescaler produces a
//   slot-advance tick every `divider` clocks while running. Each advance picks
//   the next enabled slot in the order 1 -> 2 -> 3 -> 1. Downstream channel
//   logic therefore sees at most one enabled slot at a time. Single-step
//   advances are available while stopped.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high; clears all state
//   run        in   level: 1 = free-run on prescaler ticks, 0 = stopped
//   step       in   pulse: one advance while stopped (ignored when run=1/RUN)
//   div_load   in   pulse: capture div_value into the divider register
//   div_value  in   new divider value (0 is stored as 1)
//   slot_mask  in   bit i-1 enables slot i
//   slot       out  current slot 1..3, 0 = none selected
//   slot_oh    out  one-hot of slot (bit slot-1), zero when slot = 0
//   tick       out  one-clock pulse on each prescaler expiry in RUN
//   wrap       out  one-clock pulse when an advance wraps (new <= old, old != 0)
//   busy       out  1 while the state machine is in RUN
//
// Configuration:
//   GEN_SEQ_BLANK_EN  when defined, slot_oh reads 000 for the one clock that
//                     follows each advance, then shows the new one-hot.
//
// Handshake note: there is no valid/ready traffic here. step and div_load are
// single-cycle strobes sampled on the rising edge; run and slot_mask are
// levels sampled on every rising edge.
// -----------------------------------------------------------------------------
module gen_slot_sequencer #(
    parameter int DIV_WIDTH   = 16,
    parameter int DIV_DEFAULT = 50000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 step,
    input  logic                 div_load,
    input  logic [DIV_WIDTH-1:0] div_value,
    input  logic [2:0]           slot_mask,
    output logic [1:0]           slot,
    output logic [2:0]           slot_oh,
    output logic                 tick,
    output logic                 wrap,
    output logic                 busy
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] reload;
    logic [1:0]           slot_q, slot_d;
    logic [2:0]           slot_oh_q, slot_oh_d;
    logic                 tick_q, tick_d;
    logic                 wrap_q, wrap_d;
    logic                 busy_q, busy_d;
    logic                 adv;
    logic [2:0]           nxt;

    // Returns {wrap, new_slot}. Candidates are old+1, old+2, old+3 with
    // 3 -> 1 wrap-around, so old=0 searches 1,2,3 and a lone enabled current
    // slot re-selects itself on the third candidate.
    function automatic logic [2:0] next_slot(input logic [1:0] old,
                                             input logic [2:0] mask);
        logic [1:0] cand;
        logic [1:0] found;
        logic       wr;
        cand  = old;
        found = 2'd0;
        for (int k = 0; k < 3; k++) begin
            cand = (cand == 2'd3) ? 2'd1 : cand + 2'd1;
            if (found == 2'd0 && mask[cand - 2'd1]) begin
                found = cand;
            end
        end
        wr = (old != 2'd0) && (found != 2'd0) && (found <= old);
        return {wr, found};
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] s);
        logic [2:0] oh;
        oh = 3'b000;
        if (s != 2'd0) begin
            oh[s - 2'd1] = 1'b1;
        end
        return oh;
    endfunction

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        adv     = 1'b0;
        tick_d  = 1'b0;

        // A load on the same edge as a reload is seen by that reload.
        if (div_load) begin
            div_d = (div_value == '0) ? DIV_WIDTH'(1) : div_value;
        end
        reload = div_d - DIV_WIDTH'(1);
        cnt_d  = cnt_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = reload;
                if (run) begin
                    state_d = ST_RUN;
                end else if (step) begin
                    adv = 1'b1;
                end
            end
            ST_RUN: begin
                if (cnt_q == '0) begin
                    cnt_d  = reload;
                    tick_d = 1'b1;
                    adv    = 1'b1;
                end else begin
                    cnt_d = cnt_q - DIV_WIDTH'(1);
                end
                // A tick on the stopping edge has already set adv above.
                if (!run) begin
                    state_d = ST_IDLE;
                    cnt_d   = reload;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = reload;
            end
        endcase

        nxt    = next_slot(slot_q, slot_mask);
        slot_d = adv ? nxt[1:0] : slot_q;
        wrap_d = adv & nxt[2];
        busy_d = (state_d == ST_RUN);
`ifdef GEN_SEQ_BLANK_EN
        // One dead clock after every advance, then the new slot's one-hot.
        slot_oh_d = adv ? 3'b000 : onehot(slot_q);
`else
        slot_oh_d = onehot(slot_d);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            div_q     <= DIV_WIDTH'(DIV_DEFAULT);
            cnt_q     <= DIV_WIDTH'(DIV_DEFAULT - 1);
            slot_q    <= 2'd0;
            slot_oh_q <= 3'b000;
            tick_q    <= 1'b0;
            wrap_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            slot_q    <= slot_d;
            slot_oh_q <= slot_oh_d;
            tick_q    <= tick_d;
            wrap_q    <= wrap_d;
            busy_q    <= busy_d;
        end
    end

    assign slot    = slot_q;
    assign slot_oh = slot_oh_q;
    assign tick    = tick_q;
    assign wrap    = wrap_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_gen_slot_sequencer.sv
// -----------------------------------------------------------------------------
// tb_gen_slot_sequencer
//
// Directed bench for gen_slot_sequencer. Expected slot/wrap results of each
// advance are queued as {wrap, slot} in exp_q and popped on the tick cycle.
// Inputs change and outputs are read 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_gen_slot_sequencer;

    logic        clk;
    logic        reset;
    logic        run;
    logic        step;
    logic        div_load;
    logic [15:0] div_value;
    logic [2:0]  slot_mask;
    logic [1:0]  slot;
    logic [2:0]  slot_oh;
    logic        tick;
    logic        wrap;
    logic        busy;

    int          n_checks;
    int          n_fail;
    logic [1:0]  cur_slot;
    logic [2:0]  exp_q[$];

    gen_slot_sequencer #(
        .DIV_WIDTH   (16),
        .DIV_DEFAULT (50000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .step      (step),
        .div_load  (div_load),
        .div_value (div_value),
        .slot_mask (slot_mask),
        .slot      (slot),
        .slot_oh   (slot_oh),
        .tick      (tick),
        .wrap      (wrap),
        .busy      (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] onehot(input logic [1:0] s);
        logic [2:0] oh;
        oh = 3'b000;
        if (s != 2'd0) oh[s - 2'd1] = 1'b1;
        return oh;
    endfunction

    // slot_oh right after an advance edge.
    function automatic logic [2:0] adv_oh(input logic [1:0] s);
`ifdef GEN_SEQ_BLANK_EN
        return (s == s) ? 3'b000 : 3'b000;
`else
        return onehot(s);
`endif
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int v);
        div_value = 16'(v);
        div_load  = 1'b1;
        cyc();
        div_load  = 1'b0;
    endtask

    task automatic push(input logic w, input logic [1:0] s);
        exp_q.push_back({w, s});
    endtask

    // Runs n prescaler periods of the given length; the tick lands on the
    // last cycle of each period.
    task automatic run_periods(input int period, input int n);
        logic [2:0] e;
        for (int k = 0; k < n; k++) begin
            for (int c = 1; c <= period; c++) begin
                cyc();
                if (c < period) begin
                    check("tick_quiet", 32'(tick), 32'(0));
                    check("wrap_quiet", 32'(wrap), 32'(0));
                    check("slot_hold",  32'(slot), 32'(cur_slot));
                    check("oh_hold",    32'(slot_oh), 32'(onehot(cur_slot)));
                    check("busy_run",   32'(busy), 32'(1));
                end else begin
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL exp_q_empty: got empty queue, expected an entry");
                        e = 3'b000;
                    end else begin
                        e = exp_q.pop_front();
                    end
                    cur_slot = e[1:0];
                    check("tick_pulse", 32'(tick), 32'(1));
                    check("slot_adv",   32'(slot), 32'(e[1:0]));
                    check("wrap_adv",   32'(wrap), 32'(e[2]));
                    check("oh_adv",     32'(slot_oh), 32'(adv_oh(cur_slot)));
                end
            end
        end
    endtask

    task automatic step_pulse(input logic [1:0] es, input logic ew);
        step = 1'b1;
        cyc();
        step = 1'b0;
        cur_slot = es;
        check("step_slot", 32'(slot), 32'(es));
        check("step_wrap", 32'(wrap), 32'(ew));
        check("step_tick", 32'(tick), 32'(0));
        check("step_oh",   32'(slot_oh), 32'(adv_oh(es)));
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("step_idle_tick", 32'(tick), 32'(0));
            check("step_idle_slot", 32'(slot), 32'(es));
            check("step_idle_oh",   32'(slot_oh), 32'(onehot(es)));
            check("step_idle_busy", 32'(busy), 32'(0));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks  = 0;
        n_fail    = 0;
        cur_slot  = 2'd0;
        reset     = 1'b1;
        run       = 1'b0;
        step      = 1'b0;
        div_load  = 1'b0;
        div_value = 16'd0;
        slot_mask = 3'b111;

        // Reset state, then hold after release.
        cyc();
        cyc();
        check("rst_slot", 32'(slot), 32'(0));
        check("rst_oh",   32'(slot_oh), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_tick", 32'(tick), 32'(0));
        check("rst_wrap", 32'(wrap), 32'(0));
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("post_rst_slot", 32'(slot), 32'(0));
            check("post_rst_busy", 32'(busy), 32'(0));
            check("post_rst_tick", 32'(tick), 32'(0));
        end

        // Divider 4, full mask: 1,2,3,1(wrap),2.
        do_load(4);
        run = 1'b1;
        cyc();
        check("run_busy", 32'(busy), 32'(1));
        check("run_slot", 32'(slot), 32'(0));
        check("run_tick", 32'(tick), 32'(0));
        push(0, 1); push(0, 2); push(0, 3); push(1, 1); push(0, 2);
        run_periods(4, 5);
        run = 1'b0;
        cyc();
        check("stop_busy", 32'(busy), 32'(0));
        check("stop_slot", 32'(slot), 32'(2));

        // Asynchronous reset pulse between edges, back to slot 0.
        #2 reset = 1'b1;
        #1;
        check("arst1_slot", 32'(slot), 32'(0));
        check("arst1_oh",   32'(slot_oh), 32'(0));
        #1 reset = 1'b0;
        cyc();
        cur_slot = 2'd0;

        // Mask 101 at divider 2, then 010, then 000.
        slot_mask = 3'b101;
        do_load(2);
        run = 1'b1;
        cyc();
        check("run2_busy", 32'(busy), 32'(1));
        push(0, 1); push(0, 3); push(1, 1); push(0, 3);
        run_periods(2, 4);
        slot_mask = 3'b010;
        push(1, 2); push(1, 2); push(1, 2);
        run_periods(2, 3);
        slot_mask = 3'b000;
        push(0, 0); push(0, 0);
        run_periods(2, 2);
        run = 1'b0;
        cyc();
        check("stop2_busy", 32'(busy), 32'(0));
        check("stop2_tick", 32'(tick), 32'(0));

        // Single steps while stopped, including the 3 -> 1 wrap.
        slot_mask = 3'b111;
        step_pulse(2'd1, 1'b0);
        step_pulse(2'd2, 1'b0);
        step_pulse(2'd3, 1'b0);
        step_pulse(2'd1, 1'b1);

        // step together with run: run wins, no advance.
        run  = 1'b1;
        step = 1'b1;
        cyc();
        check("steprun_busy", 32'(busy), 32'(1));
        check("steprun_slot", 32'(slot), 32'(1));
        check("steprun_wrap", 32'(wrap), 32'(0));
        step = 1'b0;
        run  = 1'b0;
        cyc();
        check("stepstop_busy", 32'(busy), 32'(0));
        check("stepstop_slot", 32'(slot), 32'(1));
        check("stepstop_tick", 32'(tick), 32'(0));

        // Divider 8, reload to 3 mid-count: first period still 8.
        do_load(8);
        run = 1'b1;
        cyc();
        check("run8_busy", 32'(busy), 32'(1));
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("run8_quiet", 32'(tick), 32'(0));
        end
        div_value = 16'd3;
        div_load  = 1'b1;
        cyc();
        div_load  = 1'b0;
        check("load3_quiet", 32'(tick), 32'(0));
        push(0, 2);
        run_periods(4, 1);
        push(0, 3); push(1, 1);
        run_periods(3, 2);

        // div_value 0 is stored as 1: tick every clock after the current period.
        div_value = 16'd0;
        div_load  = 1'b1;
        cyc();
        div_load  = 1'b0;
        check("load0_quiet", 32'(tick), 32'(0));
        push(0, 2);
        run_periods(2, 1);
        push(0, 3); push(1, 1); push(0, 2);
        run_periods(1, 3);

        // Asynchronous reset while running at slot 2.
        check("pre_arst_slot", 32'(slot), 32'(2));
        #2 reset = 1'b1;
        #1;
        check("arst2_slot", 32'(slot), 32'(0));
        check("arst2_busy", 32'(busy), 32'(0));
        check("arst2_oh",   32'(slot_oh), 32'(0));
        check("arst2_tick", 32'(tick), 32'(0));
        run = 1'b0;
        cyc();
        check("arst2_hold_slot", 32'(slot), 32'(0));
        reset = 1'b0;
        cyc();
        check("arst2_idle_busy", 32'(busy), 32'(0));
        check("arst2_idle_slot", 32'(slot), 32'(0));

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
